lcd_line_fetch: RTL and testbench
=================================

# lcd_line_fetch

Scanline prefetch stage between VRAM and the `video` output block. For each upcoming LCD line it computes the scrolled VRAM row and reads one line of packed 2-bit pixels into a double-buffered line RAM. It then serves random-access pixel reads to the `video` block from the opposite bank. Using this stage removes VRAM address generation from the pixel path and applies `lcd_xscroll` / `lcd_yscroll` with wrap-around.

## Interface
Parameters:
- `ROW_BYTES`, default 48: VRAM bytes per row (stride).
- `ROWS`, default 170: VRAM rows; the vertical wrap modulus.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `ce`  in  1  clock enable. All state advances only when `ce`=1.
- `line_start`  in  1  single-`ce` pulse: begin fetching line `line_num` and swap banks.
- `line_num`  in  8  LCD line to fetch, 0–159.
- `lcd_xscroll`  in  8  horizontal scroll in pixels.
- `lcd_yscroll`  in  8  vertical scroll in rows.
- `vram_addr`  out  13  VRAM byte address.
- `vram_rd`  out  1  read strobe. `vram_addr` is valid when this is high.
- `vram_data`  in  8  read data, valid on the `ce` cycle after `vram_rd`.
- `pix_x`  in  8  pixel column to read from the display bank, 0–159.
- `pix_data`  out  2  pixel value for `pix_x`, registered.
- `busy`  out  1  fetch in progress.
- `done`  out  1  one-`ce` pulse when the line is fully written.

## Operation
- Storage: two banks of 41 bytes each, selected by `bank`. The fetch writes bank `bank`; reads use bank `~bank`.
- `line_start` toggles `bank` and latches `line_num`, `lcd_xscroll` and `lcd_yscroll` for the whole fetch.
- FSM states: IDLE, CALC, FETCH, DRAIN.
  - IDLE → CALC on `line_start`.
  - CALC: compute `row = (line_num + yscroll) mod ROWS`.
    - Use a 9-bit sum with at most two conditional subtractions of `ROWS`. The maximum sum is 414.
    - Compute `base = row * ROW_BYTES`, 13 bits.
  - FETCH: issue N reads, with k = 0..N-1.
    - `vram_addr = base + ((xscroll[7:2] + k) mod ROW_BYTES)`.
    - The column wraps within the row and never carries into the next row.
  - DRAIN: capture the last byte, then go to IDLE and pulse `done`.
  - Pipelining: byte k is written to buffer slot k on the cycle after its address is issued.
- N = 41 with the fine-scroll feature enabled, 40 without it.
- Pixel read, with fine scroll enabled:
  - `eff = pix_x + xscroll[1:0]`, 0–162.
  - Byte = `eff[7:2]`.
  - Pixel = byte bits `[2*eff[1:0] +: 2]`, so the LSB pair is the leftmost pixel.
- `pix_x` > 159 returns `pix_data` = 0.
- `line_start` during FETCH, CALC or DRAIN: abort the current fetch, toggle `bank`, and restart at CALC with the new inputs. No `done` is pulsed for the aborted line.
- `line_start` in the same cycle as the last DRAIN cycle: the restart takes priority and `done` is suppressed.
- `vram_rd` = 1 only in FETCH.

## Timing
- Reset values:
  - `bank`=0, state IDLE.
  - `busy`=0, `done`=0, `vram_rd`=0, `vram_addr`=0, `pix_data`=0.
  - Buffer contents are undefined, but reads after reset return 0 until the first `done`.
- The following counts assume `ce` is held at 1 and `line_start` is at cycle t:
  - CALC is at t+1.
  - Reads are issued at t+2 .. t+N+1.
  - The last byte is written at t+N+2.
  - `done` is high at t+N+2; that is t+43 with fine scroll, t+42 without.
- `busy` is high from t+1 through t+N+2.
- `pix_data` has a latency of 1 `ce` cycle from `pix_x`.
- A bank swap takes effect on reads in the cycle after `line_start`.
- `ce`=0 freezes the FSM, the address counter, the read register and `done`.

## Configuration
- `LCD_XSCROLL_FINE_EN` defined:
  - N = 41 bytes per line.
  - `xscroll[1:0]` shifts pixels as described in Operation.
- `LCD_XSCROLL_FINE_EN` undefined:
  - N = 40 bytes per line.
  - `xscroll[1:0]` is ignored and `eff = pix_x`.
  - Byte slot 40 is not implemented.
  - `done` is high at t+42.

## Test plan
- Reset, then `line_start` with `line_num`=0 and both scrolls 0:
  - `vram_addr` = 0x000..0x028 on consecutive cycles.
  - `done` at t+43.
  - After a second `line_start`, `pix_x`=0 reads bits [1:0] of the byte returned for 0x000.
- `line_num`=10, `yscroll`=165: row 5, so the first `vram_addr` = 0x0F0.
- `line_num`=159, `yscroll`=255: sum 414, row 74, so the first `vram_addr` = 0xDE0 (two subtractions).
- `xscroll`=0xBD:
  - Addresses are row base +47, then +0, +1, …
  - `pix_x`=0 returns bits [3:2] of the byte at +47.
  - `pix_x`=3 returns bits [1:0] of the byte at +0.
- Second `line_start` at t+20:
  - No `done` for the first line.
  - `bank` toggles twice in total.
  - `done` arrives 43 cycles after the second pulse.
- Assert `reset_n` low mid-FETCH:
  - Outputs go to their reset values immediately; `busy` is 0.
  - `ce`=0 for 5 cycles mid-fetch delays `done` by exactly 5 cycles.

Source files
------------

// File: rtl/lcd_line_fetch.sv
// lcd_line_fetch -- scanline prefetch between VRAM and the video block.
//
// On each line_start the block swaps line-buffer banks and latches the line
// number and both scroll values. It then computes the vertically wrapped VRAM
// row and reads one line of packed 2-bit pixels into the fetch bank. The
// opposite bank serves registered random-access pixel reads.
//
// Optional feature macro: LCD_XSCROLL_FINE_EN
//   defined   : 41 bytes fetched per line; xscroll[1:0] shifts pixels.
//   undefined : 40 bytes fetched per line; xscroll[1:0] is ignored.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   ce           clock enable; every piece of state advances only when ce=1
//   line_start   one-ce pulse: swap banks, start fetching line_num
//   line_num     LCD line to fetch (0-159)
//   lcd_xscroll  horizontal scroll in pixels
//   lcd_yscroll  vertical scroll in rows
//   vram_addr    VRAM byte address, valid while vram_rd is high
//   vram_rd      VRAM read strobe
//   vram_data    VRAM read data, valid on the ce cycle after vram_rd
//   pix_x        pixel column to read from the display bank (0-159)
//   pix_data     registered pixel value for pix_x
//   busy         fetch in progress
//   done         one-ce pulse when the line is completely written
module lcd_line_fetch #(
  parameter int ROW_BYTES = 48,
  parameter int ROWS      = 170
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        line_start,
  input  logic [7:0]  line_num,
  input  logic [7:0]  lcd_xscroll,
  input  logic [7:0]  lcd_yscroll,
  output logic [12:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  input  logic [7:0]  pix_x,
  output logic [1:0]  pix_data,
  output logic        busy,
  output logic        done
);

`ifdef LCD_XSCROLL_FINE_EN
  localparam int N = 41;
`else
  localparam int N = 40;
`endif
  localparam int CW = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
  localparam int AW = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, CALC, FETCH, DRAIN} state_t;

  state_t          state_q;
  logic            bank_q;
  logic [1:0]      valid_q;      // per bank: holds a completely fetched line
  logic [7:0]      line_q;
  logic [7:0]      yscroll_q;
  logic [5:0]      xcoarse_q;
  logic [12:0]     base_q;
  logic [CW-1:0]   col_q;
  logic [5:0]      k_q;
  logic            wr_pend_q;
  logic [5:0]      wr_slot_q;
  logic [12:0]     vram_addr_q;
  logic            vram_rd_q;
  logic            busy_q;
  logic            done_q;
  logic [1:0]      pix_q;

  // Bank b occupies slots [b*N, b*N+N-1].
  logic [7:0]      buf_mem [0:2*N-1];

`ifdef LCD_XSCROLL_FINE_EN
  // Fine scroll is kept per bank so the displayed line is always shifted by
  // the value it was fetched with, even while the other bank is refilling.
  logic [1:0][1:0] fine_q;
`else
  logic            unused_fine;
  assign unused_fine = ^lcd_xscroll[1:0];
`endif

  // Row / base / column arithmetic
  logic [8:0]      sum_d;
  logic [8:0]      row_d;
  logic [12:0]     base_d;
  logic [CW-1:0]   col0_d;
  logic [CW-1:0]   col_inc_d;

  always_comb begin
    sum_d = {1'b0, line_q} + {1'b0, yscroll_q};
    row_d = sum_d;
    // Largest sum is 159+255=414, so two subtractions always reach range.
    if (row_d >= 9'(ROWS)) row_d = row_d - 9'(ROWS);
    if (row_d >= 9'(ROWS)) row_d = row_d - 9'(ROWS);
    base_d    = 13'(row_d) * 13'(ROW_BYTES);
    col0_d    = CW'(int'(xcoarse_q) % ROW_BYTES);
    // Column wraps inside the row, never carrying into the next row.
    col_inc_d = (col_q == CW'(ROW_BYTES - 1)) ? '0 : col_q + CW'(1);
  end

  // Pixel read path (display bank is ~bank_q)
  logic [7:0]      eff_d;
  logic [AW-1:0]   rd_idx_d;
  logic [AW-1:0]   wr_idx_d;
  logic [7:0]      rd_byte_d;

  always_comb begin
`ifdef LCD_XSCROLL_FINE_EN
    eff_d = pix_x + {6'd0, fine_q[~bank_q]};
`else
    eff_d = pix_x;
`endif
    rd_idx_d  = bank_q ? AW'(eff_d[7:2]) : AW'(eff_d[7:2]) + AW'(N);
    wr_idx_d  = bank_q ? AW'(wr_slot_q) + AW'(N) : AW'(wr_slot_q);
    rd_byte_d = buf_mem[rd_idx_d];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bank_q      <= 1'b0;
      valid_q     <= 2'b00;
      line_q      <= '0;
      yscroll_q   <= '0;
      xcoarse_q   <= '0;
      base_q      <= '0;
      col_q       <= '0;
      k_q         <= '0;
      wr_pend_q   <= 1'b0;
      wr_slot_q   <= '0;
      vram_addr_q <= '0;
      vram_rd_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_q       <= 2'b00;
`ifdef LCD_XSCROLL_FINE_EN
      fine_q      <= '0;
`endif
    end else if (ce) begin
      // LSB pair of a byte is the leftmost pixel.
      pix_q <= (pix_x <= 8'd159 && valid_q[~bank_q]) ?
               rd_byte_d[{eff_d[1:0], 1'b0} +: 2] : 2'b00;

      if (line_start) begin
        // Start or restart: any fetch in flight is abandoned without done.
        bank_q           <= ~bank_q;
        valid_q[~bank_q] <= 1'b0;
        line_q           <= line_num;
        yscroll_q        <= lcd_yscroll;
        xcoarse_q        <= lcd_xscroll[7:2];
`ifdef LCD_XSCROLL_FINE_EN
        fine_q[~bank_q]  <= lcd_xscroll[1:0];
`endif
        state_q          <= CALC;
        busy_q           <= 1'b1;
        done_q           <= 1'b0;
        vram_rd_q        <= 1'b0;
        vram_addr_q      <= '0;
        wr_pend_q        <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          CALC: begin
            base_q      <= base_d;
            col_q       <= col0_d;
            k_q         <= '0;
            vram_addr_q <= base_d + 13'(col0_d);
            vram_rd_q   <= 1'b1;
            state_q     <= FETCH;
          end
          FETCH: begin
            // Data for the address on the bus arrives next ce cycle.
            wr_pend_q <= 1'b1;
            wr_slot_q <= k_q;
            if (k_q == 6'(N - 1)) begin
              state_q     <= DRAIN;
              vram_rd_q   <= 1'b0;
              vram_addr_q <= '0;
              done_q      <= 1'b1;
            end else begin
              k_q         <= k_q + 6'd1;
              col_q       <= col_inc_d;
              vram_addr_q <= base_q + 13'(col_inc_d);
            end
          end
          DRAIN: begin
            wr_pend_q       <= 1'b0;
            done_q          <= 1'b0;
            busy_q          <= 1'b0;
            valid_q[bank_q] <= 1'b1;
            state_q         <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Line RAM write port; no reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (ce && wr_pend_q) begin
      buf_mem[wr_idx_d] <= vram_data;
    end
  end

  assign vram_addr = vram_addr_q;
  assign vram_rd   = vram_rd_q;
  assign busy      = busy_q;
  assign pix_data  = pix_q;
  // A restart landing on the DRAIN cycle suppresses that line's done.
  assign done      = done_q & ~(ce & line_start);

endmodule

// File: tb/tb_lcd_line_fetch.sv
module tb_lcd_line_fetch;

  localparam int RB   = 48;
  localparam int ROWS = 170;
`ifdef LCD_XSCROLL_FINE_EN
  localparam int N    = 41;
  localparam bit FINE = 1'b1;
`else
  localparam int N    = 40;
  localparam bit FINE = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        ce;
  logic        line_start;
  logic [7:0]  line_num;
  logic [7:0]  lcd_xscroll;
  logic [7:0]  lcd_yscroll;
  logic [12:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data;
  logic [7:0]  pix_x;
  logic [1:0]  pix_data;
  logic        busy;
  logic        done;

  lcd_line_fetch #(.ROW_BYTES(RB), .ROWS(ROWS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .line_start  (line_start),
    .line_num    (line_num),
    .lcd_xscroll (lcd_xscroll),
    .lcd_yscroll (lcd_yscroll),
    .vram_addr   (vram_addr),
    .vram_rd     (vram_rd),
    .vram_data   (vram_data),
    .pix_x       (pix_x),
    .pix_data    (pix_data),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] vram [0:8191];

  // Reference model: which bank is being fetched, and which line each bank holds.
  bit mbank;
  bit mv [2];
  int mL [2];
  int mX [2];
  int mY [2];
  int cL, cX, cY;
  int rx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock; the VRAM model answers a read on the ce cycle after it.
  task automatic tick();
    bit p;
    logic [12:0] a;
    p = (vram_rd === 1'b1) && (ce === 1'b1);
    a = vram_addr;
    @(posedge clk);
    #1;
    if (p) vram_data = vram[a];
  endtask

  function automatic int exp_addr(input int k);
    return ((cL + cY) % ROWS) * RB + (((cX >> 2) + k) % RB);
  endfunction

  // Pixel x of a line = pixel (scroll + x) of the wrapped VRAM row.
  function automatic logic [1:0] model_pix(input int x);
    int b;
    int row;
    int p;
    logic [7:0] byte_v;
    b = mbank ? 0 : 1;
    if (x > 159 || !mv[b]) return 2'b00;
    row = (mL[b] + mY[b]) % ROWS;
    p = (FINE ? mX[b] : (mX[b] & 252)) + x;
    byte_v = vram[row * RB + ((p / 4) % RB)];
    return 2'((byte_v >> (2 * (p % 4))) & 8'd3);
  endfunction

  task automatic start_line(input int l, input int xs, input int ys);
    line_num    = 8'(l);
    lcd_xscroll = 8'(xs);
    lcd_yscroll = 8'(ys);
    line_start  = 1'b1;
    ce          = 1'b1;
    #1;
    chk("done_with_line_start", {31'd0, done}, 32'd0);
    mbank     = ~mbank;
    mv[mbank] = 1'b0;
    cL = l; cX = xs; cY = ys;
    tick();
    line_start = 1'b0;
  endtask

  // e counts ce-enabled edges since the line_start edge.
  task automatic monitor(input int stop_e, input int stall_at, input int stall_len);
    int e;
    int w;
    int done_w;
    bit en;
    e = 0; w = 1; done_w = -1;
    for (int g = 0; g < 300; g++) begin
      chk($sformatf("busy e=%0d", e), {31'd0, busy}, {31'd0, (e <= N + 1)});
      chk($sformatf("vram_rd e=%0d", e), {31'd0, vram_rd}, {31'd0, (e >= 1 && e <= N)});
      chk($sformatf("done e=%0d", e), {31'd0, done}, {31'd0, (e == N + 1)});
      if (e >= 1 && e <= N)
        chk($sformatf("vram_addr k=%0d", e - 1), {19'd0, vram_addr}, exp_addr(e - 1));
      if (done === 1'b1 && done_w < 0) done_w = w;
      if (e == stop_e) begin
        ce = 1'b1;
        return;
      end
      if (e == N + 2) begin
        chk("done_cycle", done_w, N + 2 + stall_len);
        mv[mbank] = 1'b1;
        mL[mbank] = cL; mX[mbank] = cX; mY[mbank] = cY;
        $display("line %0d xs=%02h ys=%02h first_addr=%03h done_cycle=%0d",
                 cL, cX, cY, exp_addr(0), done_w);
        ce = 1'b1;
        return;
      end
      en = !(w > stall_at && w <= stall_at + stall_len);
      ce = en;
      tick();
      if (en) e++;
      w++;
    end
    ce = 1'b1;
    chk("monitor_bound", e, N + 2);
  endtask

  task automatic read_pix(input int x);
    pix_x = 8'(x);
    tick();
    chk($sformatf("pix x=%0d", x), {30'd0, pix_data}, {30'd0, model_pix(x)});
  endtask

  task automatic read_set();
    read_pix(0); read_pix(1); read_pix(2); read_pix(3); read_pix(4);
    read_pix(159); read_pix(160); read_pix(255);
    for (int i = 0; i < 3; i++) read_pix($urandom_range(0, 159));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " vram_rd"},   {31'd0, vram_rd},   32'd0);
    chk({tag, " vram_addr"}, {19'd0, vram_addr}, 32'd0);
    chk({tag, " busy"},      {31'd0, busy},      32'd0);
    chk({tag, " done"},      {31'd0, done},      32'd0);
    chk({tag, " pix_data"},  {30'd0, pix_data},  32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
    reset_n = 1'b0; ce = 1'b1; line_start = 1'b0;
    line_num = '0; lcd_xscroll = '0; lcd_yscroll = '0;
    vram_data = '0; pix_x = '0;
    mbank = 1'b0; mv[0] = 1'b0; mv[1] = 1'b0;
    cL = 0; cX = 0; cY = 0;
    rx = $urandom_range(0, 255);

    // Reset state
    tick(); tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();
    read_pix(0);
    read_pix(100);

    // Unscrolled line 0, then read it back from the display bank
    start_line(0, 0, 0);     monitor(-1, 1000, 0);
    start_line(1, 0, 0);     monitor(-1, 1000, 0); read_set();
    // Vertical wrap: one and two subtractions
    start_line(10, 0, 165);  monitor(-1, 1000, 0); read_set();
    start_line(159, 0, 255); monitor(-1, 1000, 0); read_set();
    // Horizontal scroll with column wrap inside the row
    start_line(3, 8'hBD, 0); monitor(-1, 1000, 0);
    start_line(4, 8'hBD, 0); monitor(-1, 1000, 0); read_set();

    // Restart mid-fetch (second pulse 20 cycles after the first)
    start_line(20, 8'hBD, 7); monitor(19, 1000, 0);
    start_line(30, 8'hBD, 9); monitor(-1, 1000, 0);
    start_line(31, 8'hBD, 9); monitor(-1, 1000, 0); read_set();

    // Restart on the DRAIN cycle suppresses done
    start_line(40, 8'hBD, 0); monitor(N + 1, 1000, 0);
    start_line(41, 8'hBD, 0); monitor(-1, 1000, 0);
    start_line(42, 8'hBD, 0); monitor(-1, 1000, 0); read_set();

    // Five ce=0 cycles mid-fetch delay done by five
    start_line(60, 8'hBD, 100); monitor(-1, 15, 5);
    start_line(61, 8'hBD, 100); monitor(-1, 1000, 0); read_set();

    // Asynchronous reset mid-fetch
    start_line(50, 8'hBD, 0); monitor(10, 1000, 0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    mbank = 1'b0; mv[0] = 1'b0; mv[1] = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    read_pix(5);
    read_pix(80);
    start_line(70, rx, 20); monitor(-1, 1000, 0);
    start_line(71, rx, 20); monitor(-1, 1000, 0); read_set();

    // Randomized lines
    for (int i = 0; i < 4; i++) begin
      start_line($urandom_range(0, 159), rx, $urandom_range(0, 255));
      monitor(-1, 1000, 0);
      for (int j = 0; j < 5; j++) read_pix($urandom_range(0, 175));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
